// File: rtl/column_selector_pkg.sv
// Shared connect4 definitions: board geometry defaults
// and the column selector FSM state encoding.
package column_selector_pkg;

  localparam int NUM_COLS_DEF = 7;
  localparam int COL_W_DEF    = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/column_selector_if.sv
// Button, board-handshake and status bundle
// for the connect4 column selector.
interface column_selector_if
  import column_selector_pkg::*;
#(
  parameter int COL_W = COL_W_DEF
);

  logic             left_en;
  logic             right_en;
  logic             drop_en;
  logic             drop_ack;
  logic             drop_ok;
  logic [COL_W-1:0] cursor_col;
  logic             drop_req;
  logic [COL_W-1:0] drop_col;
  logic             player;
  logic             move_done;
  logic             move_rejected;

  modport master (
    output left_en, right_en, drop_en,
    output drop_ack, drop_ok,
    input  cursor_col, drop_req, drop_col,
    input  player, move_done, move_rejected
  );

  modport slave (
    input  left_en, right_en, drop_en,
    input  drop_ack, drop_ok,
    output cursor_col, drop_req, drop_col,
    output player, move_done, move_rejected
  );

endinterface

// File: rtl/column_selector_rise_detect.sv
// One-bit rising edge detector against the level
// registered on the previous clock edge.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

  assign rise = d & ~q;

endmodule

// File: rtl/column_selector.sv
// Connect4 column cursor and drop-request FSM;
// all outputs registered.
module column_selector
  import column_selector_pkg::*;
#(
  parameter int NUM_COLS = NUM_COLS_DEF,
  parameter int COL_W    = COL_W_DEF
) (
  input logic               clk,
  input logic               rst,
  column_selector_if.slave  bus
);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(NUM_COLS - 1);
  localparam logic [COL_W-1:0] COL_MID = COL_W'(NUM_COLS / 2);

  logic left_ev, right_ev, drop_ev;

  rise_detect u_left (
    .clk (clk), .rst (rst),
    .d   (bus.left_en), .rise (left_ev)
  );

  rise_detect u_right (
    .clk (clk), .rst (rst),
    .d   (bus.right_en), .rise (right_ev)
  );

  rise_detect u_drop (
    .clk (clk), .rst (rst),
    .d   (bus.drop_en), .rise (drop_ev)
  );

  state_t           state, state_d;
  logic [COL_W-1:0] cursor, cursor_d;
  logic [COL_W-1:0] dcol, dcol_d;
  logic             req, req_d;
  logic             plyr, plyr_d;
  logic             done, done_d;
  logic             rej, rej_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cursor <= COL_MID;
      dcol   <= '0;
      req    <= 1'b0;
      plyr   <= 1'b0;
      done   <= 1'b0;
      rej    <= 1'b0;
    end else begin
      state  <= state_d;
      cursor <= cursor_d;
      dcol   <= dcol_d;
      req    <= req_d;
      plyr   <= plyr_d;
      done   <= done_d;
      rej    <= rej_d;
    end
  end

  always_comb begin
    state_d  = state;
    cursor_d = cursor;
    dcol_d   = dcol;
    req_d    = req;
    plyr_d   = plyr;
    done_d   = 1'b0;
    rej_d    = 1'b0;
    unique case (state)
      S_IDLE: begin
        // drop wins; left+right together cancel out
        if (drop_ev) begin
          dcol_d  = cursor;
          req_d   = 1'b1;
          state_d = S_REQ;
        end else if (left_ev && !right_ev) begin
          cursor_d = (cursor == '0) ? COL_MAX
                                    : cursor - 1'b1;
        end else if (right_ev && !left_ev) begin
          cursor_d = (cursor == COL_MAX) ? '0
                                         : cursor + 1'b1;
        end
      end
      S_REQ: begin
        if (bus.drop_ack) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          rej_d   = ~bus.drop_ok;
          plyr_d  = plyr ^ bus.drop_ok;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.cursor_col    = cursor;
  assign bus.drop_req      = req;
  assign bus.drop_col      = dcol;
  assign bus.player        = plyr;
  assign bus.move_done     = done;
  assign bus.move_rejected = rej;

endmodule

// File: tb/tb_column_selector.sv
// Directed bench for column_selector: cursor moves,
// drop handshake, reject path and async reset.
module tb_column_selector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  column_selector_if #(.COL_W(3)) bus ();

  column_selector #(
    .NUM_COLS (7),
    .COL_W    (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // m = {drop, right, left}; one-cycle press then release
  task automatic press(input logic [2:0] m);
    bus.left_en  = m[0];
    bus.right_en = m[1];
    bus.drop_en  = m[2];
    tick(1);
  endtask

  task automatic release_all();
    bus.left_en  = 1'b0;
    bus.right_en = 1'b0;
    bus.drop_en  = 1'b0;
    tick(1);
  endtask

  initial begin
    bus.left_en  = 1'b0;
    bus.right_en = 1'b0;
    bus.drop_en  = 1'b0;
    bus.drop_ack = 1'b0;
    bus.drop_ok  = 1'b0;
    tick(2);
    chk("rst_cursor", 32'(bus.cursor_col), 3);
    chk("rst_req", 32'(bus.drop_req), 0);
    chk("rst_dcol", 32'(bus.drop_col), 0);
    chk("rst_player", 32'(bus.player), 0);
    chk("rst_done", 32'(bus.move_done), 0);
    chk("rst_rej", 32'(bus.move_rejected), 0);
    rst = 1'b0;
    tick(1);

    press(3'b010); chk("right1", 32'(bus.cursor_col), 4);
    release_all();
    press(3'b010); chk("right2", 32'(bus.cursor_col), 5);
    release_all();
    press(3'b010); chk("right3", 32'(bus.cursor_col), 6);
    release_all();
    press(3'b010); chk("right_wrap", 32'(bus.cursor_col), 0);
    release_all();

    press(3'b001); chk("left_wrap", 32'(bus.cursor_col), 6);
    release_all();
    bus.left_en = 1'b1;
    tick(100);
    chk("left_held", 32'(bus.cursor_col), 5);
    release_all();

    press(3'b011); chk("lr_both", 32'(bus.cursor_col), 5);
    release_all();
    press(3'b001); release_all();
    press(3'b001); release_all();
    press(3'b001); chk("left_to2", 32'(bus.cursor_col), 2);
    release_all();

    press(3'b110);
    chk("drop_req", 32'(bus.drop_req), 1);
    chk("drop_col", 32'(bus.drop_col), 2);
    chk("drop_cursor", 32'(bus.cursor_col), 2);
    release_all();
    press(3'b010); release_all();
    chk("req_right", 32'(bus.cursor_col), 2);
    chk("req_hold", 32'(bus.drop_req), 1);
    chk("req_col", 32'(bus.drop_col), 2);

    bus.drop_ack = 1'b1;
    bus.drop_ok  = 1'b1;
    tick(1);
    bus.drop_ack = 1'b0;
    bus.drop_ok  = 1'b0;
    chk("ack_req", 32'(bus.drop_req), 0);
    chk("ack_done", 32'(bus.move_done), 1);
    chk("ack_rej", 32'(bus.move_rejected), 0);
    chk("ack_player", 32'(bus.player), 1);
    tick(1);
    chk("done_1cyc", 32'(bus.move_done), 0);
    chk("done_player", 32'(bus.player), 1);

    press(3'b100);
    chk("rej_req", 32'(bus.drop_req), 1);
    bus.drop_en  = 1'b0;
    bus.right_en = 1'b1;
    tick(2);
    bus.drop_ack = 1'b1;
    bus.drop_ok  = 1'b0;
    tick(1);
    bus.drop_ack = 1'b0;
    chk("rej_done", 32'(bus.move_done), 1);
    chk("rej_flag", 32'(bus.move_rejected), 1);
    chk("rej_player", 32'(bus.player), 1);
    tick(1);
    chk("rej_clear", 32'(bus.move_rejected), 0);
    tick(2);
    chk("held_no_ev", 32'(bus.cursor_col), 2);
    release_all();

    bus.drop_ack = 1'b1;
    bus.drop_ok  = 1'b1;
    tick(1);
    bus.drop_ack = 1'b0;
    bus.drop_ok  = 1'b0;
    chk("stray_done", 32'(bus.move_done), 0);
    chk("stray_player", 32'(bus.player), 1);
    chk("stray_req", 32'(bus.drop_req), 0);
    tick(1);

    press(3'b100);
    chk("r2_req", 32'(bus.drop_req), 1);
    bus.drop_en  = 1'b0;
    bus.right_en = 1'b1;
    rst = 1'b1;
    #2;
    chk("arst_req", 32'(bus.drop_req), 0);
    chk("arst_cursor", 32'(bus.cursor_col), 3);
    chk("arst_player", 32'(bus.player), 0);
    tick(1);
    chk("arst_done", 32'(bus.move_done), 0);
    rst = 1'b0;
    tick(1);
    chk("post_rst_edge", 32'(bus.cursor_col), 4);
    release_all();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/column_selector.md
COLUMN_SELECTOR -- requirements
Module: column_selector

Interface
REQ-001 The block SHALL have parameter NUM_COLS, default 7, giving the number of board columns (legal range 2..8).
REQ-002 The block SHALL have parameter COL_W, default 3, giving the width of column indices.
REQ-003 The block SHALL have exactly one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  system clock; all logic on posedge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 left_en  input  1  move-left enable level from a button press detector.
REQ-007 right_en  input  1  move-right enable level from a button press detector.
REQ-008 drop_en  input  1  drop-piece enable level from a button press detector.
REQ-009 drop_ack  input  1  one-cycle board acknowledge of drop_req.
REQ-010 drop_ok  input  1  board result, valid only while drop_ack=1 (1=piece placed, 0=column full).
REQ-011 cursor_col  output  COL_W  currently selected column.
REQ-012 drop_req  output  1  request to place a piece in drop_col.
REQ-013 drop_col  output  COL_W  column of the pending request.
REQ-014 player  output  1  player to move (0=P1, 1=P2).
REQ-015 move_done  output  1  one-cycle pulse after any drop_ack.
REQ-016 move_rejected  output  1  one-cycle pulse, coincident with move_done, when drop_ok=0.

Function
REQ-017 All inputs are synchronous to clk; a rising edge of each enable SHALL be detected by comparing it with its value registered on the previous clk edge.
REQ-018 An enable that stays high SHALL produce no further events; each 0->1 transition SHALL produce exactly one event.
REQ-019 FSM states SHALL be IDLE, REQ and DONE.
REQ-020 IDLE: a left event with no other event in that cycle SHALL decrement cursor_col, wrapping from 0 to NUM_COLS-1.
REQ-021 IDLE: a right event with no other event in that cycle SHALL increment cursor_col, wrapping from NUM_COLS-1 to 0.
REQ-022 IDLE: simultaneous left and right events SHALL be ignored.
REQ-023 IDLE: a drop event SHALL take priority over left/right events in the same cycle; cursor_col is unchanged, drop_col<=cursor_col, drop_req<=1, next state REQ.
REQ-024 REQ: drop_req and drop_col SHALL hold stable until the cycle drop_ack=1; in that cycle's next edge drop_req<=0 and state<=DONE.
REQ-025 drop_ack received while not in REQ SHALL be ignored.
REQ-026 On the edge that leaves REQ, player SHALL toggle iff drop_ok=1.
REQ-027 DONE SHALL last exactly one cycle, asserting move_done=1 and move_rejected=~(latched drop_ok), then return to IDLE.
REQ-028 All enable events in REQ and DONE SHALL be discarded; the edge detectors keep tracking, so a level still high on return to IDLE SHALL not create an event.
REQ-029 Latency: drop event cycle N -> drop_req=1 from N+1; drop_ack at cycle M -> move_done=1 during M+1.
REQ-030 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-031 During rst=1: state=IDLE, cursor_col=NUM_COLS/2 (3 for default), drop_col=0, drop_req=0, player=0, move_done=0, move_rejected=0, all edge-detector history=0.
REQ-032 rst asserted mid-REQ SHALL drop the request immediately (asynchronously) with no move_done pulse.
REQ-033 After rst deasserts, an enable already high SHALL count as one rising edge on the first clk edge.

Structure
REQ-034 NUM_COLS default, COL_W and the FSM state encodings SHALL live in the shared connect4 definitions package/include file.
REQ-035 One sub-module, rise_detect (1-bit registered edge detector with async reset), SHALL be instantiated three times.

Verification
REQ-036 Reset, then three right_en pulses -> cursor_col 3->4->5->6; a fourth -> 0.
REQ-037 From cursor_col=0, left_en pulse -> cursor_col=6; left_en held high 100 cycles -> exactly one decrement.
REQ-038 cursor_col=2, drop_en rises together with right_en -> drop_req=1, drop_col=2, cursor_col stays 2; right_en pulses during REQ -> no cursor change.
REQ-039 drop_ack=1, drop_ok=1 five cycles after request -> drop_req=0 next edge, move_done one cycle, move_rejected=0, player 0->1.
REQ-040 drop_ack=1, drop_ok=0 -> move_done=1, move_rejected=1, player unchanged; stray drop_ack in IDLE -> no output change.
REQ-041 rst pulse during REQ -> drop_req=0 immediately, cursor_col=3, player=0, no move_done.
